// File: rtl/multiplier_datapath_taint_track_1bit_if.sv
// Command/operand/result bundle between the sequential multiplier
// controller (master) and the shift-add datapath (slave). Every data
// signal travels with a 1-bit taint companion.
interface multiplier_datapath_taint_track_1bit_if #(
    parameter int WIDTH = 1024
);
    logic [WIDTH-1:0]   multiplicand;
    logic               multiplicand_t;
    logic [WIDTH-1:0]   multiplier;
    logic               multiplier_t;
    logic               mdld;
    logic               mdld_t;
    logic               mrld;
    logic               mrld_t;
    logic               rsclear;
    logic               rsclear_t;
    logic               rsload;
    logic               rsload_t;
    logic               rsshr;
    logic               rsshr_t;
    logic               productDone;
    logic               productDone_t;
    logic [WIDTH-1:0]   multiplierReg;
    logic               multiplierReg_t;
    logic [2*WIDTH-1:0] product;
    logic               product_t;
    logic               product_valid;
    logic               product_valid_t;

    // Controller side: issues commands and operands, observes results.
    modport master (
        output multiplicand, multiplicand_t, multiplier, multiplier_t,
        output mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
        output rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        input  multiplierReg, multiplierReg_t, product, product_t,
        input  product_valid, product_valid_t
    );

    // Datapath side: executes commands, returns register contents.
    modport slave (
        input  multiplicand, multiplicand_t, multiplier, multiplier_t,
        input  mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
        input  rsload, rsload_t, rsshr, rsshr_t, productDone, productDone_t,
        output multiplierReg, multiplierReg_t, product, product_t,
        output product_valid, product_valid_t
    );
endinterface

// File: rtl/multiplier_datapath_taint_track_1bit.sv
// Shift-add multiplier datapath with 1-bit information-flow taint per
// register. The running sum RS carries one extra carry bit above the
// 2*WIDTH product; the finished product is captured one cycle after the
// controller's FINAL shift and held with a valid flag.
//
// Optional build macro MULT_DP_TAINT_CLEAR_EN: when defined, an untainted
// rsclear declassifies the running sum and an untainted mrld declassifies
// the held product. When undefined, those taints are sticky until reset.
module multiplier_datapath_taint_track_1bit #(
    parameter int WIDTH = 1024
) (
    input  logic clk,
    input  logic rst,
    multiplier_datapath_taint_track_1bit_if.slave bus
);

    logic [WIDTH-1:0]   r_md;
    logic [WIDTH-1:0]   r_mr;
    logic [2*WIDTH:0]   r_rs;
    logic [2*WIDTH-1:0] r_product;
    logic               r_product_valid;
    logic               r_done_d;
    logic               r_done_d_t;
    logic               r_md_t;
    logic               r_mr_t;
    logic               r_rs_t;
    logic               r_product_t;
    logic               r_product_valid_t;

    logic [WIDTH:0]     w_upper_sum;
    logic               w_md_t_next;
    logic               w_mr_t_next;
    logic               w_rs_t_next;
    logic               w_product_t_next;
    logic               w_product_valid_t_next;

    // Upper half of RS plus the (pre-edge) multiplicand; the top bit is the carry.
    assign w_upper_sum = {1'b0, r_rs[2*WIDTH-1:WIDTH]} + {1'b0, r_md};

    // Operand registers: independent loads, no interaction with RS commands.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; this is what makes rsload see the old MD on a
    // same-cycle mdld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md <= '0;
            r_mr <= '0;
        end else begin
            if (bus.mdld) r_md <= bus.multiplicand;
            if (bus.mrld) r_mr <= bus.multiplier;
        end
    end

    // Running sum: clear beats load beats shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rs <= '0;
        end else if (bus.rsclear) begin
            r_rs <= '0;
        end else if (bus.rsload) begin
            r_rs[2*WIDTH:WIDTH] <= w_upper_sum;
        end else if (bus.rsshr) begin
            r_rs <= r_rs >> 1;
        end
    end

    // Product capture one cycle after FINAL; a new mrld withdraws the valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_d        <= 1'b0;
            r_done_d_t      <= 1'b0;
            r_product       <= '0;
            r_product_valid <= 1'b0;
        end else begin
            r_done_d   <= bus.productDone;
            r_done_d_t <= bus.productDone_t;
            if (r_done_d) begin
                r_product       <= r_rs[2*WIDTH-1:0];
                r_product_valid <= 1'b1;
            end else if (bus.mrld) begin
                r_product_valid <= 1'b0;
            end
        end
    end

    // Next-state taint: enable taints propagate whether or not the enable is set.
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        w_md_t_next = (r_md_t & ~bus.mdld) | (bus.mdld & bus.multiplicand_t) | bus.mdld_t;
        w_mr_t_next = (r_mr_t & ~bus.mrld) | (bus.mrld & bus.multiplier_t) | bus.mrld_t;
        w_rs_t_next = r_rs_t | (bus.rsload & r_md_t) | bus.rsload_t
                    | bus.rsshr_t | bus.rsclear_t;
        w_product_t_next       = r_product_t;
        w_product_valid_t_next = r_product_valid_t | r_done_d_t | bus.mrld_t;
`ifdef MULT_DP_TAINT_CLEAR_EN
        if (bus.rsclear && !bus.rsclear_t) w_rs_t_next = 1'b0;
        if (bus.mrld && !bus.mrld_t)       w_product_t_next = 1'b0;
        if (r_done_d)                      w_product_t_next = r_rs_t | r_mr_t | r_done_d_t;
`else
        if (r_done_d) w_product_t_next = r_product_t | r_rs_t | r_mr_t | r_done_d_t;
`endif
    end

    // Taint registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_md_t            <= 1'b0;
            r_mr_t            <= 1'b0;
            r_rs_t            <= 1'b0;
            r_product_t       <= 1'b0;
            r_product_valid_t <= 1'b0;
        end else begin
            r_md_t            <= w_md_t_next;
            r_mr_t            <= w_mr_t_next;
            r_rs_t            <= w_rs_t_next;
            r_product_t       <= w_product_t_next;
            r_product_valid_t <= w_product_valid_t_next;
        end
    end

    assign bus.multiplierReg   = r_mr;
    assign bus.multiplierReg_t = r_mr_t;
    assign bus.product         = r_product;
    assign bus.product_t       = r_product_t;
    assign bus.product_valid   = r_product_valid;
    assign bus.product_valid_t = r_product_valid_t;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_1bit.sv
// Self-checking bench for multiplier_datapath_taint_track_1bit at WIDTH=4.
// Acts as the controller, drives full multiply sequences and compares the
// held product and taints against an arithmetic/taint reference model.
module tb_multiplier_datapath_taint_track_1bit;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_datapath_taint_track_1bit_if #(.WIDTH(W)) bus ();

    multiplier_datapath_taint_track_1bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference taint state, tracked per multiply run.
    bit m_rs_t;
    bit m_prod_t;
    bit m_pv_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.mdld = 0; bus.mdld_t = 0; bus.mrld = 0; bus.mrld_t = 0;
        bus.rsclear = 0; bus.rsclear_t = 0; bus.rsload = 0; bus.rsload_t = 0;
        bus.rsshr = 0; bus.rsshr_t = 0; bus.productDone = 0; bus.productDone_t = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".product"},   64'(bus.product), 64'd0);
        check({tag, ".product_t"}, 64'(bus.product_t), 64'd0);
        check({tag, ".valid"},     64'(bus.product_valid), 64'd0);
        check({tag, ".valid_t"},   64'(bus.product_valid_t), 64'd0);
        check({tag, ".mreg"},      64'(bus.multiplierReg), 64'd0);
        check({tag, ".mreg_t"},    64'(bus.multiplierReg_t), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check_all_zero("reset");
        m_rs_t = 0; m_prod_t = 0; m_pv_t = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Full controller sequence: INIT, harmless shift, then per MR bit
    // (LSB first) an optional rsload followed by a shift; the last is FINAL.
    // shr_taint_at selects which of the W+1 shifts carries rsshr_t (-1: none).
    task automatic run_mult(input int md, input int mr, input bit md_t, input bit mr_t,
                            input int shr_taint_at, input bit done_t, input string tag);
        logic [63:0] exp_prod;
        logic [W-1:0] mr_bits;
        exp_prod = 64'(md) * 64'(mr);
        mr_bits  = W'(mr);
`ifdef MULT_DP_TAINT_CLEAR_EN
        m_rs_t   = 0;
        m_prod_t = 0;
`endif
        m_rs_t   = m_rs_t | (md_t && mr_bits != 0) | (shr_taint_at >= 0);
        m_prod_t = m_prod_t | m_rs_t | mr_t | done_t;
        m_pv_t   = m_pv_t | done_t;

        idle();
        bus.multiplicand = W'(md); bus.multiplicand_t = md_t;
        bus.multiplier = mr_bits;  bus.multiplier_t = mr_t;
        bus.mdld = 1; bus.mrld = 1; bus.rsclear = 1;
        step();
        check({tag, ".init_valid"}, 64'(bus.product_valid), 64'd0);
        check({tag, ".mreg_t"}, 64'(bus.multiplierReg_t), 64'(mr_t));

        idle();
        bus.rsshr = 1; bus.rsshr_t = (shr_taint_at == 0);
        step();
        for (int i = 0; i < W; i++) begin
            if (mr_bits[i]) begin
                idle();
                bus.rsload = 1;
                step();
                check({tag, ".mreg"}, 64'(bus.multiplierReg), 64'(mr_bits));
            end
            idle();
            bus.rsshr = 1;
            bus.rsshr_t = (shr_taint_at == i + 1);
            bus.productDone = (i == W - 1);
            bus.productDone_t = done_t && (i == W - 1);
            step();
            check({tag, ".mreg"}, 64'(bus.multiplierReg), 64'(mr_bits));
        end
        idle();
        // FINAL has landed but capture is still one edge away.
        check({tag, ".valid_early"}, 64'(bus.product_valid), 64'd0);
        step();
        check({tag, ".product"},   64'(bus.product), exp_prod);
        check({tag, ".valid"},     64'(bus.product_valid), 64'd1);
        check({tag, ".product_t"}, 64'(bus.product_t), 64'(m_prod_t));
        check({tag, ".valid_t"},   64'(bus.product_valid_t), 64'(m_pv_t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b0;
        idle();
        bus.multiplicand = '0; bus.multiplicand_t = 0;
        bus.multiplier = '0;   bus.multiplier_t = 0;
        #12;
        do_reset();

        // Untainted basic multiply and all-ones carry case.
        run_mult(13, 11, 0, 0, -1, 0, "m13x11");
        run_mult(15, 15, 0, 0, -1, 0, "m15x15");

        // Zero multiplier, then a new mrld withdraws valid but keeps product.
        run_mult(9, 0, 0, 0, -1, 0, "m9x0");
        idle();
        bus.multiplier = 4'd5; bus.mrld = 1;
        step();
        idle();
`ifdef MULT_DP_TAINT_CLEAR_EN
        m_prod_t = 0;
`endif
        check("mrld.valid",   64'(bus.product_valid), 64'd0);
        check("mrld.product", 64'(bus.product), 64'd0);
        check("mrld.mreg",    64'(bus.multiplierReg), 64'd5);

        // Tainted multiplicand reaches product through rsload.
        run_mult(5, 3, 1, 0, -1, 0, "mdt5x3");

        // Tainted multiplicand with no rsload leaves the sum clean.
        do_reset();
        run_mult(5, 0, 1, 0, -1, 0, "mdt5x0");

        // One tainted shift mid-run, then a run with an untainted clear.
        run_mult(7, 9, 0, 0, 2, 0, "shrt7x9");
        run_mult(2, 3, 0, 0, -1, 0, "after_shrt");

        // Tainted multiplier and tainted productDone.
        do_reset();
        run_mult(6, 5, 0, 1, -1, 0, "mrt6x5");
        run_mult(3, 4, 0, 0, -1, 1, "donet3x4");

        // Randomized operands and taints.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     bit'($urandom_range(0, 1)), 1'b0, -1, bit'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset between edges in the middle of a multiply.
        do_reset();
        run_mult(9, 3, 0, 0, -1, 0, "pre_async");
        idle();
        bus.multiplicand = 4'd12; bus.multiplier = 4'd7;
        bus.mdld = 1; bus.mrld = 1; bus.rsclear = 1;
        step();
        idle();
        bus.rsshr = 1;
        step();
        idle();
        bus.rsload = 1;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async");
        m_rs_t = 0; m_prod_t = 0; m_pv_t = 0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        run_mult(6, 7, 0, 0, -1, 0, "m6x7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
